wb_stage: RTL and testbench

Writeback stage of the five-stage pipeline: registers Memory-stage results into the W pipeline register, selects the result, and sign- or zero-extends load data. It drives the write port of `regfile`, which is the writer side of the register file. It also exports `rd_w`, `regwrite_w` and `result_w` to the hazard and forwarding unit, and optionally counts retired instructions.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_stage_load_ext.sv | 31 +++
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes and load funct3 values.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } resultsrc_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load extension: selects the byte/halfword addressed by the offset and sign- or zero-extends it.
module load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // offset[0] is deliberately dropped for halfwords; misalignment is handled elsewhere.
    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, result select, load extension, regfile write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_w,
    input  logic            flush_w,
    input  logic            valid_m,
    input  logic            regwrite_m,
    input  logic [1:0]      resultsrc_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] read_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [XLEN-1:0] imm_ext_m,
    input  logic [4:0]      rd_m,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            regwrite_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] result_w
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    logic            valid_q,     valid_d;
    logic            regwrite_q,  regwrite_d;
    resultsrc_e      resultsrc_q, resultsrc_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [XLEN-1:0] alu_q,       alu_d;
    logic [XLEN-1:0] rdata_q,     rdata_d;
    logic [XLEN-1:0] pc4_q,       pc4_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [4:0]      rd_q,        rd_d;

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        funct3_d    = funct3_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        if (flush_w) begin
            // Bubble: only the qualifiers matter, payload fields are left as they were.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall_w) begin
            valid_d     = valid_m;
            regwrite_d  = regwrite_m;
            resultsrc_d = resultsrc_e'(resultsrc_m);
            funct3_d    = funct3_m;
            alu_d       = alu_result_m;
            rdata_d     = read_data_m;
            pc4_d       = pc_plus4_m;
            imm_d       = imm_ext_m;
            rd_d        = rd_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= RES_ALU;
            funct3_q    <= 3'b000;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            rd_q        <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
        end
    end

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;
    logic            write_en;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (funct3_q),
        .offset (alu_q[1:0]),
        .word   (rdata_q),
        .data   (load_data)
    );

    always_comb begin
        result = alu_q;
        case (resultsrc_q)
            RES_ALU:  result = alu_q;
            RES_LOAD: result = load_data;
            RES_PC4:  result = pc4_q;
            RES_IMM:  result = imm_q;
            default:  result = alu_q;
        endcase
    end

    // x0 writes are dropped here so the hazard unit never sees x0 as a forwarding source.
    assign write_en   = valid_q & regwrite_q & (rd_q != 5'd0);
    assign we3        = write_en;
    assign regwrite_w = write_en;
    assign a3         = rd_q;
    assign rd_w       = rd_q;
    assign wd3        = result;
    assign result_w   = result;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // An instruction retires on the edge where it leaves W without being held.
    assign instret_d = (valid_q && !stall_w) ? instret_q + 64'd1 : instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a reference model.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        stall_w, flush_w, valid_m, regwrite_m;
    logic [1:0]  resultsrc_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m, imm_ext_m;
    logic [4:0]  rd_m;
    logic        we3, regwrite_w;
    logic [4:0]  a3, rd_w;
    logic [31:0] wd3, result_w;
    logic [63:0] instret_obs;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the W slot should hold, in architectural terms.
    logic        m_valid, m_regwrite, m_known;
    logic [4:0]  m_rd;
    logic [31:0] m_result;
    logic [63:0] m_instret;

`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    assign instret_obs = instret;
`else
    assign instret_obs = 64'd0;
`endif

    wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .valid_m      (valid_m),
        .regwrite_m   (regwrite_m),
        .resultsrc_m  (resultsrc_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .imm_ext_m    (imm_ext_m),
        .rd_m         (rd_m),
        .we3          (we3),
        .a3           (a3),
        .wd3          (wd3),
        .regwrite_w   (regwrite_w),
        .rd_w         (rd_w),
        .result_w     (result_w)
`ifdef WB_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned off, b, h;
        off = addr % 4;
        b   = (word >> (8 * off)) % 256;
        h   = (word >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b < 128)   ? b : b + 32'hFFFF_FF00;
            3'd4:    return b;
            3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] rs, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc4, input logic [31:0] imm);
        case (rs)
            2'd0:    return alu;
            2'd1:    return ref_load(f3, alu, rdata);
            2'd2:    return pc4;
            default: return imm;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_known = 1; m_rd = 0; m_result = 0; m_instret = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_we;
        exp_we = m_valid & m_regwrite & (m_rd != 0);
        chk({tag, ".we3"}, 64'(we3), 64'(exp_we));
        chk({tag, ".regwrite_w"}, 64'(regwrite_w), 64'(exp_we));
        if (m_known) begin
            chk({tag, ".a3"}, 64'(a3), 64'(m_rd));
            chk({tag, ".rd_w"}, 64'(rd_w), 64'(m_rd));
            chk({tag, ".wd3"}, 64'(wd3), 64'(m_result));
            chk({tag, ".result_w"}, 64'(result_w), 64'(m_result));
        end
`ifdef WB_INSTRET_EN
        chk({tag, ".instret"}, instret_obs, m_instret);
`endif
    endtask

    // Drive one cycle of M inputs at the falling edge, let the rising edge capture, then check.
    task automatic step(input string tag, input logic st, input logic fl, input logic v,
                        input logic rw, input logic [1:0] rs, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd);
        @(negedge clk);
        stall_w = st; flush_w = fl; valid_m = v; regwrite_m = rw; resultsrc_m = rs;
        funct3_m = f3; alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4;
        imm_ext_m = imm; rd_m = rd;
        @(posedge clk);
        if (m_valid && !st) m_instret = m_instret + 1;
        if (fl) begin
            m_valid = 0; m_regwrite = 0; m_known = 0;
        end else if (!st) begin
            m_valid = v; m_regwrite = rw; m_rd = rd; m_known = 1;
            m_result = ref_result(rs, f3, alu, rdata, pc4, imm);
        end
        #1;
        check_outputs(tag);
        $display("txn %s st=%0b fl=%0b v=%0b rw=%0b rs=%0d rd=%0d we3=%0b wd3=%h", tag, st, fl,
                 v, rw, rs, rd, we3, wd3);
    endtask

    task automatic bubble(input string tag);
        step(tag, 0, 0, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        chk({tag, ".we3_negedge"}, 64'(we3), 64'd0);
        reset = 1'b0;
        $display("txn %s reset pulse we3=%0b", tag, we3);
    endtask

    localparam logic [31:0] LW_WORD = 32'h80F0_7F01;

    initial begin
        reset = 1'b1;
        stall_w = 0; flush_w = 0; valid_m = 0; regwrite_m = 0; resultsrc_m = 0;
        funct3_m = 0; alu_result_m = 0; read_data_m = 0; pc_plus4_m = 0; imm_ext_m = 0; rd_m = 0;
        model_reset();
        #1;
        check_outputs("reset_init");
        @(negedge clk);
        reset = 1'b0;

        step("alu_rd5", 0, 0, 1, 1, 2'd0, 3'd0, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 5'd5);
        chk("alu_rd5.wd3_const", 64'(wd3), 64'hA5A5_A5A5);

        step("lb_off3",  0, 0, 1, 1, 2'd1, 3'b000, 32'h1003, LW_WORD, 32'h0, 32'h0, 5'd7);
        chk("lb_off3.const", 64'(wd3), 64'hFFFF_FF80);
        step("lbu_off3", 0, 0, 1, 1, 2'd1, 3'b100, 32'h1003, LW_WORD, 32'h0, 32'h0, 5'd7);
        chk("lbu_off3.const", 64'(wd3), 64'h0000_0080);
        step("lh_off2",  0, 0, 1, 1, 2'd1, 3'b001, 32'h1002, LW_WORD, 32'h0, 32'h0, 5'd7);
        chk("lh_off2.const", 64'(wd3), 64'hFFFF_80F0);
        step("lhu_off0", 0, 0, 1, 1, 2'd1, 3'b101, 32'h1000, LW_WORD, 32'h0, 32'h0, 5'd7);
        chk("lhu_off0.const", 64'(wd3), 64'h0000_7F01);
        step("lw",       0, 0, 1, 1, 2'd1, 3'b010, 32'h1000, LW_WORD, 32'h0, 32'h0, 5'd7);
        chk("lw.const", 64'(wd3), 64'(LW_WORD));
        step("lh_off1",  0, 0, 1, 1, 2'd1, 3'b001, 32'h1001, LW_WORD, 32'h0, 32'h0, 5'd7);
        step("f3_111",   0, 0, 1, 1, 2'd1, 3'b111, 32'h1003, LW_WORD, 32'h0, 32'h0, 5'd7);

        step("x0_write", 0, 0, 1, 1, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("x0_write.we3_const", 64'(we3), 64'd0);

        // Stall holds W for three cycles while M presents different data; then flush+stall.
        step("pre_stall", 0, 0, 1, 1, 2'd0, 3'd0, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 1, 1, 2'd0, 3'd0, 32'hDEAD_0000 + i, 32'h0, 32'h0, 32'h0, 5'd12);
        chk("stall.wd3_hold", 64'(wd3), 64'h1111_2222);
        step("flush_stall", 1, 1, 1, 1, 2'd0, 3'd0, 32'hBEEF_BEEF, 32'h0, 32'h0, 32'h0, 5'd13);
        chk("flush_stall.we3_const", 64'(we3), 64'd0);

        // Fresh counter for the JAL / LUI / store sequence.
        @(negedge clk);
        pulse_reset("seq_reset");
        step("jal",   0, 0, 1, 1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h104, 32'h0, 5'd1);
        chk("jal.wd3_const", 64'(wd3), 64'h104);
        step("lui",   0, 0, 1, 1, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 5'd10);
        chk("lui.wd3_const", 64'(wd3), 64'h1234_5000);
        step("store", 0, 0, 1, 0, 2'd0, 3'd0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd3);
        chk("store.we3_const", 64'(we3), 64'd0);
        bubble("seq_drain");
`ifdef WB_INSTRET_EN
        chk("seq.instret_const", instret_obs, 64'd3);
`endif

        // Reset arriving mid-cycle with a write pending in W.
        step("pending", 0, 0, 1, 1, 2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0, 5'd20);
        pulse_reset("midrun_reset");
        bubble("post_reset");

        for (int n = 0; n < 300; n++) begin
            logic [4:0] rd_r;
            rd_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), $urandom,
                 $urandom, $urandom, $urandom, rd_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
